clock_ctrl: RTL and testbench

Front-panel controller for the digital-clock datapath built from the mod-60 seconds/minutes counters and the hours counter. It generates the 1 Hz count enable, gates the carry chain, and runs the mode state machine that lets the user set hours, minutes and seconds with up/down buttons, including auto-repeat. It also produces a blink strobe for the display driver to flash the field being edited. It sits between the debounced button inputs and the counter enables (CEN/INC/DEC).

---
 rtl/clock_ctrl_if.sv | 32 +++
 rtl/clock_ctrl.sv | 141 ++++++++++++++
 tb/tb_clock_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_ctrl_if.sv
// Front-panel <-> counter-enable signal bundle for the digital-clock controller.
// All signals are plain clk-synchronous levels or single-cycle pulses; there is no valid/ready handshake.
interface clock_ctrl_if;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic       sec_ca;
    logic       min_ca;
    logic       sec_cen;
    logic       min_cen;
    logic       hr_cen;
    logic       sec_inc;
    logic       sec_dec;
    logic       min_inc;
    logic       min_dec;
    logic       hr_inc;
    logic       hr_dec;
    logic [1:0] mode;
    logic       blink;

    modport master (
        output btn_mode, btn_up, btn_down, sec_ca, min_ca,
        input  sec_cen, min_cen, hr_cen, sec_inc, sec_dec,
               min_inc, min_dec, hr_inc, hr_dec, mode, blink
    );

    modport slave (
        input  btn_mode, btn_up, btn_down, sec_ca, min_ca,
        output sec_cen, min_cen, hr_cen, sec_inc, sec_dec,
               min_inc, min_dec, hr_inc, hr_dec, mode, blink
    );
endinterface

// File: rtl/clock_ctrl.sv
// Digital-clock front panel: 1 Hz tick, carry gating, mode FSM, edit pulses with
// auto-repeat, and a blink strobe for the field being edited. The FSM state is the mode output.
module clock_ctrl #(
    parameter int PRESCALE   = 50_000_000,
    parameter int REPEAT_DLY = 25_000_000,
    parameter int REPEAT_PER = 5_000_000
) (
    input  logic         clk,
    input  logic         n_rst,
    clock_ctrl_if.slave  bus
);
    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] SET_HR  = 2'd1;
    localparam logic [1:0] SET_MIN = 2'd2;
    localparam logic [1:0] SET_SEC = 2'd3;

    localparam int CW   = $clog2(PRESCALE);
    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0] PS_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(PRESCALE / 2 - 1);
    localparam logic [RW-1:0] DLY_CNT   = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] PER_CNT   = RW'(REPEAT_PER);

    logic [1:0]    state;
    logic          mode_s, up_s, dn_s;
    logic          mode_d, up_alone_d, dn_alone_d;
    logic [CW-1:0] cnt;
    logic          blink_r, sec_cen_r;
    logic [RW-1:0] rpt_cnt;
    logic          rpt_fast, hold_ok;
    logic [5:0]    pulse_r;   // {hr_inc, hr_dec, min_inc, min_dec, sec_inc, sec_dec}

    logic          mode_edge, up_alone, dn_alone, held, press, fire, edit;
    logic [RW-1:0] rpt_thr;

    // A button only counts while held alone; pressing both cancels, releasing one re-presses the other.
    assign mode_edge = mode_s & ~mode_d;
    assign up_alone  = up_s & ~dn_s;
    assign dn_alone  = dn_s & ~up_s;
    assign held      = up_alone | dn_alone;
    assign press     = (up_alone & ~up_alone_d) | (dn_alone & ~dn_alone_d);
    assign rpt_thr   = rpt_fast ? PER_CNT : DLY_CNT;
    assign fire      = hold_ok & held & ~press & (rpt_cnt == rpt_thr);
    assign edit      = ~mode_edge & (state != RUN) & (press | fire);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            mode_s     <= 1'b0;
            up_s       <= 1'b0;
            dn_s       <= 1'b0;
            mode_d     <= 1'b0;
            up_alone_d <= 1'b0;
            dn_alone_d <= 1'b0;
            state      <= RUN;
        end else begin
            mode_s     <= bus.btn_mode;
            up_s       <= bus.btn_up;
            dn_s       <= bus.btn_down;
            mode_d     <= mode_s;
            up_alone_d <= up_alone;
            dn_alone_d <= dn_alone;
            if (mode_edge)
                state <= state + 2'd1;
        end
    end

    // Shared counter: 1 s prescaler in RUN, blink half-period timer while editing.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt       <= '0;
            blink_r   <= 1'b0;
            sec_cen_r <= 1'b0;
        end else if (mode_edge) begin
            cnt       <= '0;
            blink_r   <= 1'b0;
            sec_cen_r <= 1'b0;
        end else if (state == RUN) begin
            sec_cen_r <= (cnt == PS_LAST);
            cnt       <= (cnt == PS_LAST) ? '0 : cnt + 1'b1;
            blink_r   <= 1'b0;
        end else begin
            sec_cen_r <= 1'b0;
            if (cnt == HALF_LAST) begin
                cnt     <= '0;
                blink_r <= ~blink_r;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // rpt_cnt runs 1..threshold from each press; rpt_fast selects the shorter period after the first repeat.
    always_ff @(posedge clk) begin
        if (!n_rst || mode_edge || !held) begin
            hold_ok  <= 1'b0;
            rpt_cnt  <= '0;
            rpt_fast <= 1'b0;
        end else if (press) begin
            hold_ok  <= 1'b1;
            rpt_cnt  <= RW'(1);
            rpt_fast <= 1'b0;
        end else if (hold_ok) begin
            if (rpt_cnt == rpt_thr) begin
                rpt_cnt  <= RW'(1);
                rpt_fast <= 1'b1;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pulse_r <= '0;
        end else begin
            pulse_r <= '0;
            if (edit) begin
                case (state)
                    SET_HR:  pulse_r[5:4] <= {up_alone, dn_alone};
                    SET_MIN: pulse_r[3:2] <= {up_alone, dn_alone};
                    SET_SEC: pulse_r[1:0] <= {up_alone, dn_alone};
                    default: pulse_r      <= '0;
                endcase
            end
        end
    end

    assign bus.sec_cen = sec_cen_r;
    assign bus.min_cen = bus.sec_ca & (state == RUN);
    assign bus.hr_cen  = bus.min_ca & (state == RUN);
    assign bus.hr_inc  = pulse_r[5];
    assign bus.hr_dec  = pulse_r[4];
    assign bus.min_inc = pulse_r[3];
    assign bus.min_dec = pulse_r[2];
    assign bus.sec_inc = pulse_r[1];
    assign bus.sec_dec = pulse_r[0];
    assign bus.mode    = state;
    assign bus.blink   = blink_r;
endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: directed front-panel scenarios plus random button traffic,
// every cycle compared against an age-based reference model.
module tb_clock_ctrl;
    localparam int PRESCALE = 10;
    localparam int DLY      = 8;
    localparam int PER      = 3;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    clock_ctrl_if bus ();

    clock_ctrl #(
        .PRESCALE  (PRESCALE),
        .REPEAT_DLY(DLY),
        .REPEAT_PER(PER)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: mode number, ages since RUN/SET entry and since the current press.
    int   m_mode   = 0;
    int   run_age  = 0;
    int   set_age  = 0;
    int   hold_age = 0;
    bit   armed    = 0;
    logic p_mode = 0, pp_mode = 0, p_up = 0, pp_up = 0, p_dn = 0, pp_dn = 0;
    logic e_sec_cen = 0, e_blink = 0;
    logic [5:0] e_pulse = '0;   // {hr_inc, hr_dec, min_inc, min_dec, sec_inc, sec_dec}

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic a_up, a_dn, pa_up, pa_dn, medge, press, held, fire;
        if (!n_rst) begin
            m_mode = 0; run_age = 0; set_age = 0; hold_age = 0; armed = 0;
            p_mode = 0; pp_mode = 0; p_up = 0; pp_up = 0; p_dn = 0; pp_dn = 0;
            e_sec_cen = 0; e_blink = 0; e_pulse = '0;
            return;
        end
        a_up  = p_up & ~p_dn;
        a_dn  = p_dn & ~p_up;
        pa_up = pp_up & ~pp_dn;
        pa_dn = pp_dn & ~pp_up;
        medge = p_mode & ~pp_mode;
        press = (a_up & ~pa_up) | (a_dn & ~pa_dn);
        held  = a_up | a_dn;
        fire  = 0;
        if (medge) begin
            m_mode = (m_mode + 1) % 4;
            run_age = 0; set_age = 0; armed = 0;
            e_sec_cen = 0; e_blink = 0;
        end else begin
            if (m_mode == 0) begin
                run_age++;
                e_sec_cen = (run_age % PRESCALE == 0);
                e_blink = 0;
            end else begin
                set_age++;
                e_sec_cen = 0;
                e_blink = ((set_age / (PRESCALE / 2)) % 2) == 1;
            end
            if (!held) armed = 0;
            else if (press) begin
                armed = 1; hold_age = 0; fire = 1;
            end else if (armed) begin
                hold_age++;
                fire = (hold_age == DLY) || (hold_age > DLY && (hold_age - DLY) % PER == 0);
            end
        end
        e_pulse = '0;
        if (fire && m_mode != 0)
            e_pulse[(3 - m_mode) * 2 + (a_up ? 1 : 0)] = 1'b1;
        pp_mode = p_mode; p_mode = bus.btn_mode;
        pp_up = p_up;     p_up = bus.btn_up;
        pp_dn = p_dn;     p_dn = bus.btn_down;
    endtask

    task automatic check_cycle();
        logic [11:0] obs, exp;
        obs = {bus.sec_cen, bus.min_cen, bus.hr_cen, bus.hr_inc, bus.hr_dec, bus.min_inc,
               bus.min_dec, bus.sec_inc, bus.sec_dec, bus.mode, bus.blink};
        exp = {e_sec_cen, bus.sec_ca & (m_mode == 0), bus.min_ca & (m_mode == 0),
               e_pulse, 2'(m_mode), e_blink};
        chk("cycle", 64'(obs), 64'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check_cycle();
    endtask

    task automatic mode_press();
        bus.btn_mode = 1'b1;
        tick();
        bus.btn_mode = 1'b0;
        tick();
        tick();
    endtask

    function automatic logic [5:0] pulses();
        return {bus.hr_inc, bus.hr_dec, bus.min_inc, bus.min_dec, bus.sec_inc, bus.sec_dec};
    endfunction

    initial begin
        logic [63:0] hits;
        logic [5:0]  other;
        int          n_dec, n_inc, n_tog;
        logic        prev_blink;

        bus.btn_mode = 0; bus.btn_up = 0; bus.btn_down = 0;
        bus.sec_ca = 0;   bus.min_ca = 0;

        // Reset state, then free-running 1 s ticks.
        tick(); tick();
        chk("rst_mode", 64'(bus.mode), 64'd0);
        chk("rst_outs", 64'({bus.sec_cen, pulses(), bus.blink}), 64'd0);
        n_rst = 1'b1;
        hits = '0;
        for (int i = 1; i <= 35; i++) begin
            tick();
            if (bus.sec_cen) hits |= 64'(1) << i;
        end
        chk("sec_cen_times", hits, (64'(1) << 10) | (64'(1) << 20) | (64'(1) << 30));

        // Mode stepping and a long hold.
        for (int k = 1; k <= 4; k++) begin
            mode_press();
            chk("mode_step", 64'(bus.mode), 64'(k % 4));
        end
        bus.btn_mode = 1'b1;
        repeat (20) tick();
        bus.btn_mode = 1'b0;
        tick();
        chk("mode_hold", 64'(bus.mode), 64'd1);

        // Auto-repeat on hours.
        hits = '0; other = '0;
        bus.btn_up = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (bus.hr_inc) hits |= 64'(1) << t;
            other |= pulses() & 6'b011111;
        end
        chk("hr_repeat", hits, (64'(1) << 2) | (64'(1) << 10) | (64'(1) << 13) |
                               (64'(1) << 16) | (64'(1) << 19));
        chk("hr_other", 64'(other), 64'd0);
        bus.btn_up = 1'b0;
        tick(); tick();

        // Both buttons on minutes.
        mode_press();
        chk("mode_min", 64'(bus.mode), 64'd2);
        n_dec = 0; n_inc = 0;
        bus.btn_down = 1'b1;
        for (int t = 0; t < 10; t++) begin
            if (t == 4) bus.btn_up = 1'b1;
            tick();
            n_dec += int'(bus.min_dec);
            n_inc += int'(bus.min_inc);
        end
        chk("min_dec_once", 64'(n_dec), 64'd1);
        chk("min_inc_none", 64'(n_inc), 64'd0);
        bus.btn_down = 1'b0;
        tick();
        chk("min_inc_wait", 64'(bus.min_inc), 64'd0);
        tick();
        chk("min_inc_rel", 64'(bus.min_inc), 64'd1);
        bus.btn_up = 1'b0;
        tick(); tick();

        // Carry gating in RUN versus SET_SEC, plus blink cadence.
        mode_press();
        mode_press();
        chk("mode_run", 64'(bus.mode), 64'd0);
        bus.sec_ca = 1'b1; bus.min_ca = 1'b1;
        #1;
        chk("carry_run", 64'({bus.min_cen, bus.hr_cen}), 64'b11);
        mode_press(); mode_press(); mode_press();
        chk("mode_sec", 64'(bus.mode), 64'd3);
        chk("carry_set", 64'({bus.min_cen, bus.hr_cen}), 64'b00);
        chk("blink_entry", 64'(bus.blink), 64'd0);
        n_tog = 0; n_inc = 0;
        prev_blink = bus.blink;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (bus.blink !== prev_blink) n_tog++;
            prev_blink = bus.blink;
            n_inc += int'(bus.sec_cen);
        end
        chk("blink_toggles", 64'(n_tog), 64'd4);
        chk("sec_cen_set", 64'(n_inc), 64'd0);
        bus.sec_ca = 1'b0; bus.min_ca = 1'b0;

        // Reset in the middle of an auto-repeat hold.
        bus.btn_up = 1'b1;
        repeat (12) tick();
        n_rst = 1'b0;
        tick();
        chk("rst_edit_mode", 64'(bus.mode), 64'd0);
        chk("rst_edit_outs", 64'({bus.sec_cen, pulses(), bus.blink}), 64'd0);
        n_rst = 1'b1;
        hits = '0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus.sec_cen) hits |= 64'(1) << i;
        end
        chk("rst_first_tick", hits, 64'(1) << 10);
        bus.btn_up = 1'b0;
        tick();

        // Random button and carry traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0)  bus.btn_up   = ~bus.btn_up;
            if ($urandom_range(0, 7) == 0)  bus.btn_down = ~bus.btn_down;
            if ($urandom_range(0, 19) == 0) bus.btn_mode = ~bus.btn_mode;
            bus.sec_ca = ($urandom_range(0, 3) == 0);
            bus.min_ca = ($urandom_range(0, 3) == 0);
            n_rst = ($urandom_range(0, 149) != 0);
            tick();
        end
        n_rst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
